mult_control_fsm: RTL and testbench

//  Control sequencer for the shift-and-add multiplier; drives the register-file write decoder.

---
 rtl/mult_pkg.sv | 46 ++++
 rtl/mult_bit_counter.sv | 35 +++
 rtl/mult_control_fsm.sv | 140 ++++++++++++++
 tb/tb_mult_control_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier control slice.
// Holds the register write-select codes, the ALU and source-select codes,
// the sequencer state enum, and a helper that sizes the iteration counter.
package mult_pkg;

    // Register-file write-select codes; REG_NONE suppresses the write.
    localparam logic [2:0] REG_R0   = 3'd0;
    localparam logic [2:0] REG_R1   = 3'd1;
    localparam logic [2:0] REG_R2   = 3'd2;
    localparam logic [2:0] REG_R3   = 3'd3;
    localparam logic [2:0] REG_R4   = 3'd4;
    localparam logic [2:0] REG_RP0  = 3'd5;
    localparam logic [2:0] REG_RP1  = 3'd6;
    localparam logic [2:0] REG_NONE = 3'd7;

    typedef enum logic [1:0] {
        ALU_PASS      = 2'b00,
        ALU_ADD       = 2'b01,
        ALU_SHR_CARRY = 2'b10,
        ALU_SHR_LINK  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        SRC_BUS  = 2'b00,
        SRC_ALU  = 2'b01,
        SRC_ZERO = 2'b10
    } src_sel_e;

    typedef enum logic [3:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StClr,
        StAdd,
        StShiftLo,
        StShiftHi,
        StCopy,
        StDone
    } state_e;

    // Counter width for a given operand width; at least one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Iteration counter for the multiplier sequencer.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset, clears the count
//   clr    in   synchronous clear
//   en     in   advance the count by one
//   last   out  count equals WIDTH-1 (final iteration)
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_q;

    assign last = (cnt_q == CW'(WIDTH - 1));

    // Holds at the terminal value instead of wrapping; CLR restarts it.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt_q <= '0;
        end else if (en && !last) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/mult_control_fsm.sv
// Control sequencer for the shift-and-add multiplier.
// Loads A into R0 and B into R1, clears RP0 and the carry, runs WIDTH
// add/shift iterations, copies the low product half into RP1 and pulses sDone.
// All outputs are Moore outputs decoded from the registered state.
// Ports:
//   sClk      in   clock
//   sReset    in   synchronous active-high reset
//   sStart    in   start request, honoured only in IDLE
//   sMultLsb  in   current multiplier LSB, R1[0]
//   sSelDeco  out  register write select (7 = no write)
//   sAluOp    out  00 PASS, 01 ADD, 10 SHR_CARRY, 11 SHR_LINK
//   sSrcSel   out  00 input bus, 01 ALU result, 10 zero
//   sCarryEn  out  capture ALU carry this cycle
//   sBusy     out  high outside IDLE
//   sDone     out  one-cycle completion pulse
module mult_control_fsm
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SELECTION = 3
) (
    input  logic                 sClk,
    input  logic                 sReset,
    input  logic                 sStart,
    input  logic                 sMultLsb,
    output logic [SELECTION-1:0] sSelDeco,
    output logic [1:0]           sAluOp,
    output logic [1:0]           sSrcSel,
    output logic                 sCarryEn,
    output logic                 sBusy,
    output logic                 sDone
);

    state_e   state_q, state_d;
    logic     cnt_last;
    logic [2:0] sel;
    alu_op_e  alu_op;
    src_sel_e src_sel;

    mult_bit_counter #(
        .WIDTH(WIDTH)
    ) u_bit_counter (
        .clk  (sClk),
        .reset(sReset),
        .clr  (state_q == StClr),
        .en   (state_q == StShiftHi),
        .last (cnt_last)
    );

    // State register
    always_ff @(posedge sClk) begin
        if (sReset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (sStart) state_d = StLoadA;
            StLoadA:   state_d = StLoadB;
            StLoadB:   state_d = StClr;
            // R1 was just written, so sMultLsb is the next multiplier bit.
            StClr:     state_d = sMultLsb ? StAdd : StShiftLo;
            StAdd:     state_d = StShiftLo;
            StShiftLo: state_d = StShiftHi;
            StShiftHi: begin
                if (cnt_last) begin
                    state_d = StCopy;
                end else begin
                    state_d = sMultLsb ? StAdd : StShiftLo;
                end
            end
            StCopy:    state_d = StDone;
            StDone:    state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output decode; forced to idle values while reset is asserted.
    always_comb begin
        sel      = REG_NONE;
        alu_op   = ALU_PASS;
        src_sel  = SRC_BUS;
        sCarryEn = 1'b0;
        sBusy    = 1'b0;
        sDone    = 1'b0;
        if (!sReset) begin
            sBusy = (state_q != StIdle);
            unique case (state_q)
                StIdle: ;
                StLoadA: begin
                    sel     = REG_R0;
                    src_sel = SRC_BUS;
                end
                StLoadB: begin
                    sel     = REG_R1;
                    src_sel = SRC_BUS;
                end
                StClr: begin
                    sel      = REG_RP0;
                    src_sel  = SRC_ZERO;
                    sCarryEn = 1'b1;
                end
                StAdd: begin
                    sel      = REG_RP0;
                    alu_op   = ALU_ADD;
                    src_sel  = SRC_ALU;
                    sCarryEn = 1'b1;
                end
                StShiftLo: begin
                    sel     = REG_R1;
                    alu_op  = ALU_SHR_LINK;
                    src_sel = SRC_ALU;
                end
                StShiftHi: begin
                    sel      = REG_RP0;
                    alu_op   = ALU_SHR_CARRY;
                    src_sel  = SRC_ALU;
                    sCarryEn = 1'b1;
                end
                StCopy: begin
                    sel     = REG_RP1;
                    alu_op  = ALU_PASS;
                    src_sel = SRC_ALU;
                end
                StDone: sDone = 1'b1;
                default: sBusy = 1'b0;
            endcase
        end
    end

    assign sSelDeco = SELECTION'(sel);
    assign sAluOp   = alu_op;
    assign sSrcSel  = src_sel;

endmodule

// File: tb/tb_mult_control_fsm.sv
// Self-checking bench for mult_control_fsm. A behavioural register-file/ALU
// model reacts to the sequencer outputs and feeds sMultLsb back; each run is
// checked step by step against a sequence derived from the bits of B, plus
// latency and the final product against A*B.
module tb_mult_control_fsm;

    localparam int W = 8;

    logic       sClk;
    logic       sReset;
    logic       sStart;
    logic       sMultLsb;
    logic [2:0] sSelDeco;
    logic [1:0] sAluOp;
    logic [1:0] sSrcSel;
    logic       sCarryEn;
    logic       sBusy;
    logic       sDone;

    mult_control_fsm #(
        .WIDTH    (W),
        .SELECTION(3)
    ) dut (
        .sClk    (sClk),
        .sReset  (sReset),
        .sStart  (sStart),
        .sMultLsb(sMultLsb),
        .sSelDeco(sSelDeco),
        .sAluOp  (sAluOp),
        .sSrcSel (sSrcSel),
        .sCarryEn(sCarryEn),
        .sBusy   (sBusy),
        .sDone   (sDone)
    );

    initial sClk = 1'b0;
    always #5 sClk = ~sClk;

    int tests;
    int fails;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step kinds of the control sequence
    localparam int K_LOAD_A = 0, K_LOAD_B = 1, K_CLR = 2, K_ADD = 3, K_SLO = 4;
    localparam int K_SHI = 5, K_COPY = 6, K_DONE = 7, K_IDLE = 8;

    // Expected {sel, op, src, carry_en, busy, done} for each step kind.
    function automatic logic [9:0] exp_out(input int kind);
        case (kind)
            K_LOAD_A: return {3'd0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
            K_LOAD_B: return {3'd1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
            K_CLR:    return {3'd5, 2'b00, 2'b10, 1'b1, 1'b1, 1'b0};
            K_ADD:    return {3'd5, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0};
            K_SLO:    return {3'd1, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0};
            K_SHI:    return {3'd5, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0};
            K_COPY:   return {3'd6, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
            K_DONE:   return {3'd7, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
            default:  return {3'd7, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
        endcase
    endfunction

    function automatic logic [9:0] dut_out();
        return {sSelDeco, sAluOp, sSrcSel, sCarryEn, sBusy, sDone};
    endfunction

    // Datapath model: R0..R4, RP0 (5), RP1 (6), carry flag.
    logic [7:0] r [0:6];
    logic       c;
    logic [7:0] cur_a, cur_b;

    // Applies the write requested this cycle (takes effect at the next edge).
    task automatic model_step();
        logic [8:0] sum;
        logic [7:0] res;
        logic       newc;
        res  = 8'h00;
        newc = c;
        case (sSrcSel)
            2'b00: res = (sSelDeco == 3'd0) ? cur_a : cur_b;
            2'b01: begin
                case (sAluOp)
                    2'b00: res = r[1];
                    2'b01: begin
                        sum  = {1'b0, r[5]} + {1'b0, r[0]};
                        res  = sum[7:0];
                        newc = sum[8];
                    end
                    2'b10: begin
                        res  = {c, r[5][7:1]};
                        newc = 1'b0;
                    end
                    default: res = {r[5][0], r[1][7:1]};
                endcase
            end
            default: begin
                res  = 8'h00;
                newc = 1'b0;
            end
        endcase
        if (sSelDeco != 3'd7) r[sSelDeco] = res;
        if (sCarryEn) c = newc;
        sMultLsb = r[1][0];
    endtask

    // Global protocol monitors
    logic prev_done = 1'b0;
    always @(negedge sClk) begin
        check_eq("done_twice", 32'(prev_done & sDone), 32'd0);
        check_eq("sel56_idle", 32'((sSelDeco == 3'd5 || sSelDeco == 3'd6) && !sBusy), 32'd0);
        prev_done = sDone;
    end

    task automatic check_idle(input string tag);
        check_eq(tag, 32'(dut_out()), 32'(exp_out(K_IDLE)));
    endtask

    // One multiply. inject: pulse sStart during a SHIFT_HI. hold: keep sStart
    // high throughout and check the IDLE/LOAD_A restart afterwards.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input bit inject, input bit hold);
        int kinds[$];
        int done_at;
        bit injected;
        kinds = {K_LOAD_A, K_LOAD_B, K_CLR};
        for (int i = 0; i < W; i++) begin
            if (b[i]) kinds.push_back(K_ADD);
            kinds.push_back(K_SLO);
            kinds.push_back(K_SHI);
        end
        kinds.push_back(K_COPY);
        kinds.push_back(K_DONE);

        done_at  = -1;
        injected = 1'b0;
        @(negedge sClk);
        cur_a  = a;
        cur_b  = b;
        sStart = 1'b1;
        @(posedge sClk);
        #1;
        if (!hold) sStart = 1'b0;
        for (int s = 0; s < kinds.size(); s++) begin
            @(negedge sClk);
            check_eq($sformatf("a%0h_b%0h_step%0d_k%0d", a, b, s, kinds[s]),
                     32'(dut_out()), 32'(exp_out(kinds[s])));
            if (sDone && done_at < 0) done_at = s;
            model_step();
            if (!hold) begin
                if (inject && !injected && kinds[s] == K_SHI && s > 8) begin
                    sStart   = 1'b1;
                    injected = 1'b1;
                end else begin
                    sStart = 1'b0;
                end
            end
        end
        check_eq($sformatf("latency_b%0h", b), 32'(done_at), 32'(3 + 2 * W + $countones(b) + 1));
        check_eq($sformatf("product_%0hx%0h", a, b), 32'({r[5], r[6]}), 32'(a * b));
        if (hold) begin
            @(negedge sClk);
            check_eq("hold_idle", 32'(dut_out()), 32'(exp_out(K_IDLE)));
            @(negedge sClk);
            check_eq("hold_restart", 32'(dut_out()), 32'(exp_out(K_LOAD_A)));
            sStart = 1'b0;
            sReset = 1'b1;
            @(negedge sClk);
            sReset = 1'b0;
            check_idle("hold_abort");
        end
        @(negedge sClk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        sReset   = 1'b1;
        sStart   = 1'b0;
        sMultLsb = 1'b0;
        c        = 1'b0;
        for (int i = 0; i < 7; i++) r[i] = 8'h00;
        cur_a = 8'h00;
        cur_b = 8'h00;
        repeat (2) @(posedge sClk);
        @(negedge sClk);
        check_idle("reset_state");
        sReset = 1'b0;
        @(negedge sClk);
        check_idle("idle_no_start");

        run_op(8'h05, 8'h00, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b0, 1'b0);
        run_op(8'h03, 8'h05, 1'b1, 1'b0);
        run_op(8'hA7, 8'h3C, 1'b0, 1'b1);

        // Reset held two cycles starting in the first ADD
        @(negedge sClk);
        cur_a  = 8'hFF;
        cur_b  = 8'hFF;
        sStart = 1'b1;
        @(posedge sClk);
        #1 sStart = 1'b0;
        for (int s = 0; s < 4; s++) begin
            @(negedge sClk);
            model_step();
        end
        check_eq("mid_add_state", 32'(dut_out()), 32'(exp_out(K_ADD)));
        sReset = 1'b1;
        @(negedge sClk);
        check_idle("reset_mid_add_1");
        @(negedge sClk);
        check_idle("reset_mid_add_2");
        sReset = 1'b0;
        @(negedge sClk);
        check_idle("after_reset");

        for (int n = 0; n < 6; n++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
